// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer
// Brief    : TB4004 instruction fetch front end. Runs the 8-phase cycle
//            counter, owns the PC and circular return stack, latches
//            opr/opa and second words, and resolves jumps, calls, returns
//            and FIN indirect fetches.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_sequencer #(
    parameter int STACK_DEPTH = 3
) (
    input  logic        clk,
    input  logic        rstN,
    input  logic        stepEn,
    input  logic [7:0]  romData,
    input  logic [7:0]  pairData,
    input  logic        ccIn,
    input  logic        regZeroIn,
    output logic [11:0] romAddr,
    output logic [11:0] pc,
    output logic [2:0]  cycle,
    output logic [3:0]  opr,
    output logic [3:0]  opa,
    output logic [7:0]  operand,
    output logic        secondWord
);

    localparam int               c_SP_W     = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [c_SP_W-1:0] c_SP_LAST = c_SP_W'(STACK_DEPTH - 1);
    localparam logic [2:0]       c_PHASE_M1 = 3'd3;
    localparam logic [2:0]       c_PHASE_X3 = 3'd7;
    localparam logic [3:0]       c_OP_JCN   = 4'h1;
    localparam logic [3:0]       c_OP_FIM   = 4'h2;
    localparam logic [3:0]       c_OP_FIN   = 4'h3;  // shared with JIN, split by opa[0]
    localparam logic [3:0]       c_OP_JUN   = 4'h4;
    localparam logic [3:0]       c_OP_JMS   = 4'h5;
    localparam logic [3:0]       c_OP_ISZ   = 4'h7;
    localparam logic [3:0]       c_OP_BBL   = 4'hC;

    logic [2:0]        r_cycle;
    logic [11:0]       r_pc;
    logic [3:0]        r_opr;
    logic [3:0]        r_opa;
    logic [7:0]        r_operand;
    logic              r_secondWord;
    logic [c_SP_W-1:0] r_sp;
    logic [11:0]       r_stack [STACK_DEPTH];

    logic [11:0]       w_pcInc;
    logic              w_isFin;
    logic              w_isJin;
    logic              w_isTwoCycle;
    logic [c_SP_W-1:0] w_spInc;
    logic [c_SP_W-1:0] w_spDec;
    logic [11:0]       w_nextPc;
    logic              w_nextSecond;
    logic              w_push;
    logic              w_pop;

    assign w_pcInc = r_pc + 12'd1;
    assign w_isFin = (r_opr == c_OP_FIN) && !r_opa[0];
    assign w_isJin = (r_opr == c_OP_FIN) &&  r_opa[0];
    assign w_spInc = (r_sp == c_SP_LAST) ? '0 : r_sp + c_SP_W'(1);
    assign w_spDec = (r_sp == '0) ? c_SP_LAST : r_sp - c_SP_W'(1);

    // Two-word instructions as seen by the latched opcode
    always_comb begin
        w_isTwoCycle = 1'b0;
        case (r_opr)
            c_OP_JCN, c_OP_JUN, c_OP_JMS, c_OP_ISZ: w_isTwoCycle = 1'b1;
            c_OP_FIM, c_OP_FIN:                     w_isTwoCycle = !r_opa[0];
            default:                                w_isTwoCycle = 1'b0;
        endcase
    end

    // End-of-instruction-cycle PC and stack decisions, applied on the X3 edge
    always_comb begin
        w_nextPc     = w_pcInc;
        w_nextSecond = 1'b0;
        w_push       = 1'b0;
        w_pop        = 1'b0;
        if (!r_secondWord) begin
            if (w_isTwoCycle) begin
                w_nextSecond = 1'b1;
            end else if (w_isJin) begin
                w_nextPc = {w_pcInc[11:8], pairData};
            end else if (r_opr == c_OP_BBL) begin
                w_nextPc = r_stack[w_spDec];
                w_pop    = 1'b1;
            end
        end else begin
            // pc addresses the second word here, so the jump page is that of pc+1
            case (r_opr)
                c_OP_JUN: w_nextPc = {r_opa, r_operand};
                c_OP_JMS: begin
                    w_nextPc = {r_opa, r_operand};
                    w_push   = 1'b1;
                end
                c_OP_JCN: if (ccIn)       w_nextPc = {w_pcInc[11:8], r_operand};
                c_OP_ISZ: if (!regZeroIn) w_nextPc = {w_pcInc[11:8], r_operand};
                c_OP_FIN: w_nextPc = r_pc;
                default:  w_nextPc = w_pcInc;
            endcase
        end
    end

    // Core sequencing registers: phase counter, instruction latches, PC
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_cycle      <= 3'd0;
            r_pc         <= 12'd0;
            r_opr        <= 4'd0;
            r_opa        <= 4'd0;
            r_operand    <= 8'd0;
            r_secondWord <= 1'b0;
            r_sp         <= '0;
        end else if (stepEn) begin
            r_cycle <= r_cycle + 3'd1;
            if (r_cycle == c_PHASE_M1) begin
                if (!r_secondWord) begin
                    r_opr <= romData[7:4];
                    r_opa <= romData[3:0];
                end else begin
                    r_operand <= romData;
                end
            end
            if (r_cycle == c_PHASE_X3) begin
                r_secondWord <= w_nextSecond;
                r_pc         <= w_nextPc;
                if (w_push) begin
                    r_sp <= w_spInc;
                end else if (w_pop) begin
                    r_sp <= w_spDec;
                end
            end
        end
    end

    // Return stack storage; overflow silently overwrites the oldest entry
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int i = 0; i < STACK_DEPTH; i++) begin
                r_stack[i] <= 12'd0;
            end
        end else if (stepEn && (r_cycle == c_PHASE_X3) && w_push) begin
            r_stack[r_sp] <= w_pcInc;
        end
    end

    // FIN redirects the second-cycle fetch to the register-pair address
    assign romAddr    = (r_secondWord && w_isFin) ? {r_pc[11:8], pairData} : r_pc;
    assign pc         = r_pc;
    assign cycle      = r_cycle;
    assign opr        = r_opr;
    assign opa        = r_opa;
    assign operand    = r_operand;
    assign secondWord = r_secondWord;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_sequencer
// Brief    : Self-checking bench for fetch_sequencer. An instruction-level
//            reference model (ROM array, PC, circular return stack) predicts
//            every fetch, latch and PC update.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rstN;
    logic        stepEn;
    logic [7:0]  romData;
    logic [7:0]  pairData;
    logic        ccIn;
    logic        regZeroIn;
    logic [11:0] romAddr;
    logic [11:0] pc;
    logic [2:0]  cycle;
    logic [3:0]  opr;
    logic [3:0]  opa;
    logic [7:0]  operand;
    logic        secondWord;

    logic [7:0]  rom [0:4095];
    assign romData = rom[romAddr];

    fetch_sequencer #(.STACK_DEPTH(3)) dut (
        .clk        (clk),
        .rstN       (rstN),
        .stepEn     (stepEn),
        .romData    (romData),
        .pairData   (pairData),
        .ccIn       (ccIn),
        .regZeroIn  (regZeroIn),
        .romAddr    (romAddr),
        .pc         (pc),
        .cycle      (cycle),
        .opr        (opr),
        .opa        (opa),
        .operand    (operand),
        .secondWord (secondWord)
    );

    always #5 clk = ~clk;

    int          nChecks = 0;
    int          nPass   = 0;
    int          nFail   = 0;
    logic [11:0] expPc;
    int          expCycle;
    logic [11:0] mStack [3];
    int          mSp;
    logic        stallOn = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) nPass++;
        else begin
            nFail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        expPc    = 12'd0;
        expCycle = 0;
        mSp      = 0;
        for (int i = 0; i < 3; i++) mStack[i] = 12'd0;
    endtask

    task automatic push(input logic [11:0] v);
        mStack[mSp] = v;
        mSp = (mSp + 1) % 3;
    endtask

    task automatic pop(output logic [11:0] v);
        mSp = (mSp + 2) % 3;
        v = mStack[mSp];
    endtask

    // One enabled clock, optionally preceded by a random stall that must hold state
    task automatic tick();
        if (stallOn && ($urandom_range(0, 3) == 0)) begin
            stepEn = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
            check("stall_cycle", cycle, expCycle);
            check("stall_pc", pc, expPc);
        end
        stepEn = 1'b1;
        @(posedge clk);
        #1;
        expCycle = (expCycle + 1) % 8;
        check("cycle", cycle, expCycle);
    endtask

    // Execute one whole instruction (one or two instruction cycles) against the model
    task automatic runInstr(input logic cc, input logic rz, input logic [7:0] pair);
        logic [7:0]  b0, opnd;
        logic [3:0]  hi, lo;
        logic        two, fin;
        logic [11:0] w2, inc, nxt, fAddr;
        ccIn      = cc;
        regZeroIn = rz;
        pairData  = pair;
        b0 = rom[expPc];
        hi = b0[7:4];
        lo = b0[3:0];
        two = (hi == 4'h1) || (hi == 4'h4) || (hi == 4'h5) || (hi == 4'h7) ||
              (((hi == 4'h2) || (hi == 4'h3)) && !lo[0]);
        fin = (hi == 4'h3) && !lo[0];
        check("romAddr_w1", romAddr, expPc);
        check("secondWord_w1", secondWord, 0);
        repeat (4) tick();
        check("opr", opr, hi);
        check("opa", opa, lo);
        check("secondWord_mid", secondWord, 0);
        repeat (4) tick();
        if (!two) begin
            inc = expPc + 12'd1;
            if (hi == 4'h3)      nxt = {inc[11:8], pair};
            else if (hi == 4'hC) pop(nxt);
            else                 nxt = inc;
        end else begin
            w2 = expPc + 12'd1;
            expPc = w2;
            check("pc_w2", pc, w2);
            check("secondWord_w2", secondWord, 1);
            fAddr = fin ? {w2[11:8], pair} : w2;
            check("romAddr_w2", romAddr, fAddr);
            opnd = rom[fAddr];
            repeat (4) tick();
            check("operand", operand, opnd);
            check("opr_held", opr, hi);
            repeat (4) tick();
            inc = w2 + 12'd1;
            case (hi)
                4'h1: nxt = cc ? {inc[11:8], opnd} : inc;
                4'h3: nxt = w2;
                4'h4: nxt = {lo, opnd};
                4'h5: begin push(inc); nxt = {lo, opnd}; end
                4'h7: nxt = !rz ? {inc[11:8], opnd} : inc;
                default: nxt = inc;
            endcase
        end
        expPc = nxt;
        check("pc_next", pc, nxt);
        check("secondWord_end", secondWord, 0);
    endtask

    task automatic checkResetOutputs(input string tag);
        check({tag, "_cycle"}, cycle, 0);
        check({tag, "_pc"}, pc, 0);
        check({tag, "_romAddr"}, romAddr, 0);
        check({tag, "_opr"}, opr, 0);
        check({tag, "_opa"}, opa, 0);
        check({tag, "_operand"}, operand, 0);
        check({tag, "_secondWord"}, secondWord, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstN = 1'b0; stepEn = 1'b0; pairData = 8'h00; ccIn = 1'b0; regZeroIn = 1'b0;
        for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
        modelReset();
        repeat (3) @(posedge clk);
        #1;
        checkResetOutputs("reset");
        @(negedge clk) rstN = 1'b1;
        #1;

        // Directed program: LDM, JUN, JMS/BBL, JCN page crossing, FIN, stack wrap
        rom[12'h000] = 8'hD5;
        rom[12'h001] = 8'h40; rom[12'h002] = 8'h10;
        rom[12'h010] = 8'h52; rom[12'h011] = 8'h00;
        rom[12'h200] = 8'hC0;
        rom[12'h012] = 8'h40; rom[12'h013] = 8'hFE;
        rom[12'h0FE] = 8'h14; rom[12'h0FF] = 8'h40;
        rom[12'h140] = 8'h40; rom[12'h141] = 8'hFE;
        rom[12'h100] = 8'h40; rom[12'h101] = 8'h30;
        rom[12'h030] = 8'h30; rom[12'h077] = 8'hAB;
        rom[12'h031] = 8'h50; rom[12'h032] = 8'h40;
        rom[12'h040] = 8'h50; rom[12'h041] = 8'h50;
        rom[12'h050] = 8'h50; rom[12'h051] = 8'h60;
        rom[12'h060] = 8'h50; rom[12'h061] = 8'h70;
        rom[12'h070] = 8'hC0; rom[12'h062] = 8'hC0;
        rom[12'h052] = 8'hC0; rom[12'h042] = 8'hC0;

        runInstr(1'b0, 1'b0, 8'h00);              // LDM 5
        check("ldm_pc", pc, 12'h001);
        runInstr(1'b0, 1'b0, 8'h00);              // JUN 0x010
        runInstr(1'b0, 1'b0, 8'h00);              // JMS 0x200
        check("jms_pc", pc, 12'h200);
        runInstr(1'b0, 1'b0, 8'h00);              // BBL
        check("bbl_pc", pc, 12'h012);
        runInstr(1'b0, 1'b0, 8'h00);              // JUN 0x0FE
        runInstr(1'b1, 1'b0, 8'h00);              // JCN taken
        check("jcn_taken_pc", pc, 12'h140);
        runInstr(1'b0, 1'b0, 8'h00);              // JUN 0x0FE
        runInstr(1'b0, 1'b0, 8'h00);              // JCN not taken
        check("jcn_fall_pc", pc, 12'h100);
        runInstr(1'b0, 1'b0, 8'h00);              // JUN 0x030
        runInstr(1'b0, 1'b0, 8'h77);              // FIN
        check("fin_pc", pc, 12'h031);
        repeat (4) runInstr(1'b0, 1'b0, 8'h00);   // four nested JMS
        repeat (4) runInstr(1'b0, 1'b0, 8'h00);   // four BBL
        check("wrap_return_pc", pc, 12'h062);

        // Directed 5-clock freeze
        stepEn = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("freeze_cycle", cycle, expCycle);
        check("freeze_pc", pc, expPc);

        // Random ROM image, random conditions and random stalls
        for (int i = 0; i < 4096; i++) rom[i] = 8'($urandom);
        stallOn = 1'b1;
        for (int n = 0; n < 300; n++) begin
            runInstr(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
        end
        stallOn = 1'b0;

        // Reset in the middle of an instruction cycle
        repeat (5) tick();
        #2;
        rstN = 1'b0;
        #1;
        checkResetOutputs("midreset");
        @(negedge clk) rstN = 1'b1;
        modelReset();
        #1;
        rom[12'h000] = 8'hC0;                     // BBL must pop a cleared entry
        runInstr(1'b0, 1'b0, 8'h00);
        check("post_reset_bbl_pc", pc, 12'h000);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
`default_nettype wire
